// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with valid/ready handshake and iterative shift-add multiplier
//
// Accepts one operand pair and opcode per handshake. AND/OR/ADD/SUB/XOR results are
// registered on the accept edge. MUL (when MUL_EN != 0) runs one multiplier bit per cycle.
// The flagged result is held until the consumer takes it.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      operands/opcode presented
//   in_ready   out  1      block is idle and will accept this cycle
//   num1       in   WIDTH  operand A
//   num2       in   WIDTH  operand B
//   selector   in   3      opcode
//   out_valid  out  1      y/flags valid
//   out_ready  in   1      consumer takes the result this cycle
//   y          out  WIDTH  result
//   carry      out  1      ADD carry / SUB borrow
//   zero       out  1      result is zero
//   overflow   out  1      signed overflow (ADD/SUB), nonzero upper product half (MUL)
//   busy       out  1      multiply in progress
`timescale 1ns/1ps
module seq_alu #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [2:0]       selector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   product_next;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 accept;
  logic                 start_mul;
  logic                 mul_last;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     alu_y;
  logic                 alu_carry;
  logic                 alu_ovf;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);

  assign accept    = in_valid & in_ready;
  assign start_mul = accept && (selector == OP_MUL) && (MUL_EN != 0);
  // Counter is loaded with WIDTH, so the step that takes it from 1 to 0 handles the last bit.
  assign mul_last  = (state == BUSY) && (cnt == CW'(1));

  // Multiplicand is pre-shifted each step, so the current multiplier LSB adds it directly.
  assign product_next = mplier[0] ? (product + mcand) : product;

  // One extra bit on both paths: MSB is the ADD carry or the SUB borrow.
  assign sum  = {1'b0, num1} + {1'b0, num2};
  assign diff = {1'b0, num1} - {1'b0, num2};

  always_comb begin
    alu_y     = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (selector)
      OP_AND: alu_y = num1 & num2;
      OP_OR:  alu_y = num1 | num2;
      OP_ADD: begin
        alu_y     = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_y     = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
        alu_ovf   = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff[WIDTH-1] != num1[WIDTH-1]);
      end
      OP_XOR: alu_y = num1 ^ num2;
      // Reserved codes, and 110 when the multiplier is disabled, fall through to zero.
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = start_mul ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (mul_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      product  <= '0;
      mcand    <= '0;
      mplier   <= '0;
      y        <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;

      if (start_mul) begin
        cnt     <= CNT_LOAD;
        product <= '0;
        mcand   <= {{WIDTH{1'b0}}, num1};
        mplier  <= num2;
      end else if (accept) begin
        y        <= alu_y;
        carry    <= alu_carry;
        overflow <= alu_ovf;
        zero     <= (alu_y == '0);
      end

      if (state == BUSY) begin
        cnt     <= cnt - CW'(1);
        product <= product_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        if (mul_last) begin
          y        <= product_next[WIDTH-1:0];
          carry    <= 1'b0;
          overflow <= |product_next[2*WIDTH-1:WIDTH];
          zero     <= (product_next[WIDTH-1:0] == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (8-bit, 8-bit no-MUL, 16-bit builds)
`timescale 1ns/1ps
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       in_valid, in_ready, out_valid, out_ready, busy, carry, zero, overflow;
  logic [7:0] num1, num2, y;
  logic [2:0] selector;

  logic       nm_in_valid, nm_in_ready, nm_out_valid, nm_out_ready, nm_busy;
  logic       nm_carry, nm_zero, nm_overflow;
  logic [7:0] nm_num1, nm_num2, nm_y;
  logic [2:0] nm_selector;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_busy;
  logic        w_carry, w_zero, w_overflow;
  logic [15:0] w_num1, w_num2, w_y;
  logic [2:0]  w_selector;

  seq_alu #(.WIDTH(8), .MUL_EN(1)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .selector(selector), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .carry(carry), .zero(zero),
    .overflow(overflow), .busy(busy)
  );

  seq_alu #(.WIDTH(8), .MUL_EN(0)) u_nomul (
    .clk(clk), .reset(reset), .in_valid(nm_in_valid), .in_ready(nm_in_ready),
    .num1(nm_num1), .num2(nm_num2), .selector(nm_selector), .out_valid(nm_out_valid),
    .out_ready(nm_out_ready), .y(nm_y), .carry(nm_carry), .zero(nm_zero),
    .overflow(nm_overflow), .busy(nm_busy)
  );

  seq_alu #(.WIDTH(16), .MUL_EN(1)) u_w16 (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .num1(w_num1), .num2(w_num2), .selector(w_selector), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .y(w_y), .carry(w_carry), .zero(w_zero),
    .overflow(w_overflow), .busy(w_busy)
  );

  typedef struct packed {
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        v;
  } res_t;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Reference arithmetic: results from plain integer math on w-bit unsigned operands.
  function automatic res_t model_op(input int w, input longint unsigned a, input longint unsigned b,
                                    input int sel, input bit mul_en);
    longint unsigned mask, half, full;
    longint sa, sb, r, lo, hi;
    res_t o;
    o    = '0;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    sa   = (a >= half) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = (b >= half) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    lo   = -longint'(half);
    hi   = longint'(half) - 1;
    full = 0;
    r    = 0;
    case (sel)
      0: full = a & b;
      1: full = a | b;
      2: begin
        full = a + b;
        o.c  = (full > mask);
        r    = sa + sb;
        o.v  = (r < lo) || (r > hi);
      end
      4: begin
        full = (a - b) & mask;
        o.c  = (a < b);
        r    = sa - sb;
        o.v  = (r < lo) || (r > hi);
      end
      5: full = a ^ b;
      6: if (mul_en) begin
        full = a * b;
        o.v  = ((full >> w) != 0);
      end
      default: full = 0;
    endcase
    o.y = 16'(full & mask);
    o.z = ((full & mask) == 0);
    return o;
  endfunction

  // Transaction-level model of the 8-bit DUT: one op outstanding, result visible
  // from the accept edge (non-MUL) or 8 edges later (MUL), held until taken.
  bit   m_pending     = 1'b0;
  bit   m_after_reset = 1'b0;
  bit   m_ov;
  int   m_avail       = 0;
  res_t m_exp;

  always @(posedge clk) begin
    m_ov = m_pending && (cyc >= m_avail);
    cyc  = cyc + 1;
    if (reset) begin
      m_pending     = 1'b0;
      m_after_reset = 1'b1;
    end else if (m_ov && out_ready) begin
      m_pending = 1'b0;
    end else if (!m_pending && in_valid) begin
      m_pending     = 1'b1;
      m_after_reset = 1'b0;
      m_exp         = model_op(8, num1, num2, selector, 1'b1);
      m_avail       = cyc + ((selector == 3'b110) ? 8 : 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", in_ready, !m_pending);
      check("out_valid", out_valid, m_pending && (cyc >= m_avail));
      check("busy", busy, m_pending && (cyc < m_avail));
      if (m_pending && (cyc >= m_avail)) begin
        check("y", y, m_exp.y);
        check("carry", carry, m_exp.c);
        check("zero", zero, m_exp.z);
        check("overflow", overflow, m_exp.v);
      end else if (m_after_reset) begin
        check("rst_y", y, 0);
        check("rst_flags", {carry, zero, overflow}, 0);
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        input int hold, input bit noisy, input bit lit,
                        input logic [7:0] ey, input bit ec, input bit ez, input bit ev, input int elat);
    int n;
    int lat;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("in_ready_wait");
    in_valid = 1'b1; num1 = a; num2 = b; selector = sel;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (noisy) begin
        in_valid  = 1'($urandom_range(0, 1));
        num1      = 8'($urandom);
        num2      = 8'($urandom);
        selector  = 3'($urandom);
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) timeout_fail("out_valid_wait");
    out_ready = 1'b0;
    if (lit) begin
      check("lat", lat, elat);
      check("lit_y", y, ey);
      check("lit_carry", carry, ec);
      check("lit_zero", zero, ez);
      check("lit_ovf", overflow, ev);
    end
    repeat (hold) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        num1     = 8'($urandom);
        num2     = 8'($urandom);
        selector = 3'($urandom);
      end
      @(negedge clk);
    end
    if (lit && hold > 0) begin
      check("held_y", y, ey);
      check("held_flags", {carry, zero, overflow}, {ec, ez, ev});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic nm_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    res_t e;
    int   n;
    int   lat;
    e = model_op(8, a, b, sel, 1'b0);
    n = 0;
    while (nm_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("nm_ready_wait");
    nm_in_valid = 1'b1; nm_num1 = a; nm_num2 = b; nm_selector = sel;
    @(negedge clk);
    nm_in_valid = 1'b0;
    lat = 1;
    while (nm_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (lat >= 40) timeout_fail("nm_valid_wait");
    check("nm_lat", lat, 1);
    check("nm_y", nm_y, e.y);
    check("nm_flags", {nm_carry, nm_zero, nm_overflow}, {e.c, e.z, e.v});
    nm_out_ready = 1'b1;
    @(negedge clk);
    nm_out_ready = 1'b0;
  endtask

  task automatic w_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel,
                      input bit lit, input logic [15:0] ey, input bit ec, input bit ez, input bit ev);
    res_t e;
    int   n;
    int   lat;
    e = model_op(16, a, b, sel, 1'b1);
    n = 0;
    while (w_in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout_fail("w_ready_wait");
    w_in_valid = 1'b1; w_num1 = a; w_num2 = b; w_selector = sel;
    @(negedge clk);
    w_in_valid = 1'b0;
    lat = 1;
    while (w_out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    if (lat >= 60) timeout_fail("w_valid_wait");
    check("w_lat", lat, (sel == 3'b110) ? 17 : 1);
    check("w_y", w_y, e.y);
    check("w_flags", {w_carry, w_zero, w_overflow}, {e.c, e.z, e.v});
    if (lit) begin
      check("w_lit_y", w_y, ey);
      check("w_lit_flags", {w_carry, w_zero, w_overflow}, {ec, ez, ev});
    end
    w_out_ready = 1'b1;
    @(negedge clk);
    w_out_ready = 1'b0;
    check("w_ready_after", w_in_ready, 1);
  endtask

  function automatic logic [7:0] pick8();
    logic [7:0] corners [4];
    corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h80; corners[3] = 8'h7F;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; num1 = '0; num2 = '0; selector = '0;
    nm_in_valid = 1'b0; nm_out_ready = 1'b0; nm_num1 = '0; nm_num2 = '0; nm_selector = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_num1 = '0; w_num2 = '0; w_selector = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_y", y, 0);
    check("reset_flags", {carry, zero, overflow}, 0);
    check("reset_nm_ready", nm_in_ready, 1);
    check("reset_w_y", w_y, 0);
    cmp_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);

    run_op(8'hF0, 8'h20, 3'b010, 0, 0, 1, 8'h10, 1, 0, 0, 1);
    run_op(8'h05, 8'h07, 3'b100, 0, 0, 1, 8'hFE, 1, 0, 0, 1);
    run_op(8'h80, 8'h01, 3'b100, 0, 0, 1, 8'h7F, 0, 0, 1, 1);
    run_op(8'h0C, 8'h0B, 3'b110, 0, 0, 1, 8'h84, 0, 0, 0, 9);
    run_op(8'h20, 8'h10, 3'b110, 0, 0, 1, 8'h00, 0, 1, 1, 9);
    run_op(8'h7F, 8'h01, 3'b010, 0, 0, 1, 8'h80, 0, 0, 1, 1);
    run_op(8'h3C, 8'hA5, 3'b011, 0, 0, 1, 8'h00, 0, 1, 0, 1);
    run_op(8'hFF, 8'hFF, 3'b111, 0, 0, 1, 8'h00, 0, 1, 0, 1);
    run_op(8'hAA, 8'h55, 3'b001, 5, 1, 1, 8'hFF, 0, 0, 0, 1);

    in_valid = 1'b1; num1 = 8'h0C; num2 = 8'h0B; selector = 3'b110;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_mul_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_y", y, 0);
    check("post_rst_flags", {carry, zero, overflow}, 0);
    run_op(8'hAA, 8'h0F, 3'b000, 0, 0, 1, 8'h0A, 0, 0, 0, 1);

    for (int i = 0; i < 250; i++) begin
      run_op(pick8(), pick8(), 3'($urandom), $urandom_range(0, 3), 1, 0, 8'h00, 0, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    nm_op(8'h0C, 8'h0B, 3'b110);
    nm_op(8'hF0, 8'h20, 3'b010);
    for (int i = 0; i < 30; i++) nm_op(pick8(), pick8(), 3'($urandom));

    w_op(16'hFFFF, 16'h0001, 3'b010, 1, 16'h0000, 1, 1, 0);
    w_op(16'h0100, 16'h0100, 3'b110, 1, 16'h0000, 0, 1, 1);
    for (int i = 0; i < 30; i++) w_op(16'($urandom), 16'($urandom), 3'($urandom), 0, 16'h0000, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
